// File: rtl/pb_debounce_filter.sv
// rtl/pb_debounce_filter.sv - counter-based push-button debouncer with press/release strobes
module pb_debounce_filter #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int STABLE_TICKS = 10,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_raw,
    output logic pb_clean,
    output logic pb_rise,
    output logic pb_fall,
    output logic pb_busy
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(STABLE_TICKS);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    logic pb_in;
    logic s;
    logic tick;

    // Inversion ahead of the synchronizer so reset value 0 always means "released".
    assign pb_in = (ACTIVE_LOW != 0) ? ~pb_raw : pb_raw;
    assign s     = sync2_q;
    assign tick  = (presc_q == PRESC_LAST);

    always_comb begin
        sync1_d = pb_in;
        sync2_d = sync1_q;
        presc_d = tick ? '0 : presc_q + PW'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s != clean_q) begin
                    state_d = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                // Reversion is checked before the tick so a bounce on a tick cycle never accepts.
                if (s == clean_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick && (cnt_q == CNT_LAST)) begin
                    clean_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            presc_q <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign pb_clean = clean_q;
    assign pb_rise  = rise_q;
    assign pb_fall  = fall_q;
    assign pb_busy  = (state_q == ST_QUALIFY);

endmodule
